// File: rtl/wb_load_unit.sv
// Writeback-stage load unit: in-order outstanding-load tracking, load data alignment/extension and
// registered regfile write. Defining WB_UNALIGNED_EN adds the LWL/LWR merge with the old rd value.
module wb_load_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int REG_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [3:0]                  req_op,
  input  logic [$clog2(DATA_W/8)-1:0] req_off,
  input  logic [REG_W-1:0]            req_rd,
  input  logic [DATA_W-1:0]           req_old,
  input  logic                        resp_valid,
  input  logic [DATA_W-1:0]           resp_data,
  output logic                        wb_valid,
  output logic [REG_W-1:0]            wb_regf,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        err_orphan
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int SH_W  = OFF_W + 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    OP_LB = 4'd0, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD, OP_LWL, OP_LWR
  } op_e;

  logic [3:0]       r_op  [DEPTH];
  logic [OFF_W-1:0] r_off [DEPTH];
  logic [REG_W-1:0] r_rd  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, r_drop;
  logic             r_err;
  logic             r_wb_valid;
  logic [REG_W-1:0] r_wb_regf;
  logic [DATA_W-1:0] r_wb_data;

  logic w_push, w_pop, w_drop_rsp, w_orphan, w_unused_old;
  logic [3:0]        w_h_op;
  logic [OFF_W-1:0]  w_h_off;
  logic [REG_W-1:0]  w_h_rd;
  logic [SH_W-1:0]   w_byte_sh, w_half_sh, w_word_sh;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_ld_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req_ready  = ({1'b0, r_count} + {1'b0, r_drop}) < (CNT_W + 1)'(DEPTH);
  // A request presented during flush is dropped even though req_ready may be high.
  assign w_push     = req_valid && req_ready && !flush;
  assign w_drop_rsp = resp_valid && (r_drop != '0);
  assign w_pop      = resp_valid && (r_drop == '0) && (r_count != '0);
  assign w_orphan   = resp_valid && (r_drop == '0) && (r_count == '0);
  assign w_unused_old = ^req_old;

  assign w_h_op  = r_op[r_rd_ptr];
  assign w_h_off = r_off[r_rd_ptr];
  assign w_h_rd  = r_rd[r_rd_ptr];

  // NOTE: descriptor storage has no reset; only pointers/counters define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op[r_wr_ptr]  <= req_op;
      r_off[r_wr_ptr] <= req_off;
      r_rd[r_wr_ptr]  <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_orphan) r_err <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= r_drop + r_count - CNT_W'(w_pop) - CNT_W'(w_drop_rsp);
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        r_drop  <= r_drop - CNT_W'(w_drop_rsp);
      end
    end
  end

  // Little-endian lane selection: halves and words align down to their natural boundary.
  assign w_byte_sh = {w_h_off, 3'b000};
  assign w_half_sh = {w_h_off & ~OFF_W'(1), 3'b000};
  assign w_word_sh = {w_h_off & ~OFF_W'(3), 3'b000};
  assign w_byte    = resp_data[w_byte_sh +: 8];
  assign w_half    = resp_data[w_half_sh +: 16];
  assign w_word    = resp_data[w_word_sh +: 32];

`ifdef WB_UNALIGNED_EN
  logic [31:0] r_old [DEPTH];
  logic [31:0] w_h_old, w_lwl, w_lwr;
  logic [4:0]  w_lwl_sh, w_lwr_sh;

  always_ff @(posedge clk) begin
    if (w_push) r_old[r_wr_ptr] <= req_old[31:0];
  end

  assign w_h_old  = r_old[r_rd_ptr];
  assign w_lwl_sh = {~w_h_off[1:0], 3'b000};
  assign w_lwr_sh = {w_h_off[1:0], 3'b000};
  assign w_lwl    = (w_word << w_lwl_sh) | (w_h_old & ~(32'hFFFF_FFFF << w_lwl_sh));
  assign w_lwr    = (w_word >> w_lwr_sh) | (w_h_old & ~(32'hFFFF_FFFF >> w_lwr_sh));
`endif

  always_comb begin
    w_ld_data = DATA_W'($signed(w_word));
    case (w_h_op)
      OP_LB:  w_ld_data = DATA_W'($signed(w_byte));
      OP_LBU: w_ld_data = DATA_W'(w_byte);
      OP_LH:  w_ld_data = DATA_W'($signed(w_half));
      OP_LHU: w_ld_data = DATA_W'(w_half);
      OP_LWU: w_ld_data = DATA_W'(w_word);
      OP_LD:  w_ld_data = resp_data;
`ifdef WB_UNALIGNED_EN
      OP_LWL: w_ld_data = DATA_W'($signed(w_lwl));
      OP_LWR: w_ld_data = DATA_W'($signed(w_lwr));
`endif
      default: w_ld_data = DATA_W'($signed(w_word));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_regf  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_pop && (w_h_rd != '0);
      if (w_pop) begin
        r_wb_regf <= w_h_rd;
        r_wb_data <= w_ld_data;
      end
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_regf    = r_wb_regf;
  assign wb_data    = r_wb_data;
  assign err_orphan = r_err;
endmodule
